// File: rtl/dcache_stb_wport_if.sv
// Store-buffer and memory write-through bus for the dcache store write port.
//
// Store-buffer side:
//   stb2dcache_req/addr/wdata/sel_byte : store drain request and payload (held until ack)
//   dcache2stb_ack                     : one-cycle completion pulse
// Memory side:
//   dcache2mem_req/addr/wdata/sel      : write-through request and payload
//   mem2dcache_ack                     : memory accepted the write
//
// master : the environment (store buffer plus memory)
// slave  : the dcache write port
interface dcache_stb_wport_if;
    logic        stb2dcache_req;
    logic [7:0]  stb2dcache_addr;
    logic [15:0] stb2dcache_wdata;
    logic [3:0]  stb2dcache_sel_byte;
    logic        dcache2stb_ack;

    logic        dcache2mem_req;
    logic [7:0]  dcache2mem_addr;
    logic [15:0] dcache2mem_wdata;
    logic [3:0]  dcache2mem_sel;
    logic        mem2dcache_ack;

    modport master (
        output stb2dcache_req, stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte,
        input  dcache2stb_ack,
        input  dcache2mem_req, dcache2mem_addr, dcache2mem_wdata, dcache2mem_sel,
        output mem2dcache_ack
    );

    modport slave (
        input  stb2dcache_req, stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte,
        output dcache2stb_ack,
        output dcache2mem_req, dcache2mem_addr, dcache2mem_wdata, dcache2mem_sel,
        input  mem2dcache_ack
    );
endinterface

// File: rtl/dcache_stb_wport.sv
// DCache write port for store-buffer drains. One store at a time: look it up
// in a direct-mapped array, merge the enabled nibble lanes on a hit (no
// allocate on miss), write it through to memory, then acknowledge.
//
// Ports:
//   clk        : clock, all logic on posedge
//   rst_n      : synchronous reset, ACTIVE HIGH despite the name
//   bus        : store-buffer request/ack and memory write-through (slave side)
//   fill_en    : line fill from the read-miss path, any state
//   fill_addr  : fill address (index + tag)
//   fill_data  : fill line data
//   busy       : high whenever the FSM is not IDLE
//   hit_count  : saturating store hit count
//   miss_count : saturating store miss count
//
// state  | meaning
// IDLE   | waiting for a store request; captures payload when req seen
// LOOKUP | one cycle: tag compare, lane merge on hit, count hit/miss
// MEM_WR | write-through held on the memory bus until mem ack
// RESP   | one-cycle ack to the store buffer
module dcache_stb_wport #(
    parameter int NUM_LINES = 16,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    dcache_stb_wport_if.slave   bus,
    input  logic                fill_en,
    input  logic [7:0]          fill_addr,
    input  logic [15:0]         fill_data,
    output logic                busy,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 8 - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WR, RESP} state_t;

    state_t state_q, state_d;

    logic [7:0]  addr_q;
    logic [15:0] wdata_q;
    logic [3:0]  sel_q;
    logic        ack_q;
    logic        mem_req_q;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [15:0]          data_q [NUM_LINES];

    logic [IDX_W-1:0] st_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] st_tag;
    logic             lookup_live;
    logic             hit;
    logic             fill_clash;
    logic             merge_en;
    logic [15:0]      merged;

    assign st_idx   = addr_q[IDX_W-1:0];
    assign st_tag   = addr_q[7:IDX_W];
    assign fill_idx = fill_addr[IDX_W-1:0];

    // A zero lane mask is a no-op store: it skips both the array and the counters.
    assign lookup_live = (state_q == LOOKUP) && (sel_q != 4'b0000);
    assign hit         = valid_q[st_idx] && (tag_q[st_idx] == st_tag);
    // A fill landing on the store's line in the same edge overrides the merge,
    // and the store is then accounted as a miss.
    assign fill_clash  = fill_en && (fill_idx == st_idx);
    // rst_n is active high, so !rst_n means "not in reset".
    assign merge_en    = lookup_live && hit && !fill_clash && !rst_n;

    always_comb begin
        merged = data_q[st_idx];
        for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) begin
                merged[4*i +: 4] = wdata_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.stb2dcache_req) state_d = LOOKUP;
            LOOKUP:  state_d = (sel_q == 4'b0000) ? RESP : MEM_WR;
            MEM_WR:  if (bus.mem2dcache_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            ack_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            busy       <= 1'b0;
            valid_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= (state_d == RESP);
            mem_req_q <= (state_d == MEM_WR);
            busy      <= (state_d != IDLE);

            if (state_q == IDLE && bus.stb2dcache_req) begin
                addr_q  <= bus.stb2dcache_addr;
                wdata_q <= bus.stb2dcache_wdata;
                sel_q   <= bus.stb2dcache_sel_byte;
            end

            if (lookup_live) begin
                if (hit && !fill_clash) begin
                    if (hit_count != '1) hit_count <= hit_count + 1'b1;
                end else begin
                    if (miss_count != '1) miss_count <= miss_count + 1'b1;
                end
            end

            if (fill_en) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (merge_en) begin
            data_q[st_idx] <= merged;
        end
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_addr[7:IDX_W];
            data_q[fill_idx] <= fill_data;
        end
    end

    // The memory payload comes straight from the capture registers, which
    // only change in IDLE, so it is stable for the whole MEM_WR stall.
    assign bus.dcache2stb_ack   = ack_q;
    assign bus.dcache2mem_req   = mem_req_q;
    assign bus.dcache2mem_addr  = addr_q;
    assign bus.dcache2mem_wdata = wdata_q;
    assign bus.dcache2mem_sel   = sel_q;
endmodule

// File: tb/tb_dcache_stb_wport.sv
// Directed bench for dcache_stb_wport: store misses/hits, lane merge, long
// memory stall, empty-mask store, mid-transaction reset, fill collision and
// counter saturation.
module tb_dcache_stb_wport;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fill_en;
    logic [7:0]  fill_addr;
    logic [15:0] fill_data;
    logic        busy;
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;

    dcache_stb_wport_if sif ();

    dcache_stb_wport #(.NUM_LINES(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (sif.slave),
        .fill_en    (fill_en),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .busy       (busy),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Results of the most recent store
    int          lat;
    int          mem_cyc;
    int          memack_cyc;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic [3:0]  m_sel;
    bit          stable;
    bit          busy_ok;

    // lat counts cycles with the request cycle as cycle 1, ack cycle inclusive.
    // mem_wait = number of MEM_WR cycles with mem ack held low.
    task automatic do_store(input logic [7:0] a, input logic [15:0] d, input logic [3:0] s,
                            input int mem_wait, input bit fill_lookup, input logic [15:0] fd);
        int cyc;
        bit done;
        @(negedge clk);
        sif.stb2dcache_req      = 1'b1;
        sif.stb2dcache_addr     = a;
        sif.stb2dcache_wdata    = d;
        sif.stb2dcache_sel_byte = s;
        cyc = 1; done = 1'b0; lat = 0; mem_cyc = 0; memack_cyc = 0;
        stable = 1'b1; busy_ok = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            fill_en   = fill_lookup && (cyc == 2);
            fill_addr = a;
            fill_data = fd;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (sif.dcache2stb_ack === 1'b1) begin
                lat  = cyc;
                done = 1'b1;
                sif.stb2dcache_req = 1'b0;
            end
            if (sif.dcache2mem_req === 1'b1) begin
                mem_cyc++;
                if (mem_cyc == 1) begin
                    m_addr  = sif.dcache2mem_addr;
                    m_wdata = sif.dcache2mem_wdata;
                    m_sel   = sif.dcache2mem_sel;
                end else if (m_addr !== sif.dcache2mem_addr || m_wdata !== sif.dcache2mem_wdata ||
                             m_sel !== sif.dcache2mem_sel) begin
                    stable = 1'b0;
                end
                sif.mem2dcache_ack = (mem_cyc > mem_wait);
                if (sif.mem2dcache_ack) memack_cyc = cyc;
            end else begin
                sif.mem2dcache_ack = 1'b0;
            end
        end
        sif.mem2dcache_ack = 1'b0;
        fill_en = 1'b0;
        if (!done) begin
            chk("store_timeout", 32'd0, 32'd1);
            sif.stb2dcache_req = 1'b0;
        end
    endtask

    task automatic do_fill(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        fill_en = 1'b1; fill_addr = a; fill_data = d;
        @(negedge clk);
        fill_en = 1'b0;
    endtask

    initial begin
        bit any_ack;
        bit saw_req;
        rst_n = 1'b1;
        fill_en = 1'b0; fill_addr = '0; fill_data = '0;
        sif.stb2dcache_req = 1'b0; sif.stb2dcache_addr = '0;
        sif.stb2dcache_wdata = '0; sif.stb2dcache_sel_byte = '0;
        sif.mem2dcache_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;

        // Reset state
        chk("rst_ack", sif.dcache2stb_ack, 1'b0);
        chk("rst_memreq", sif.dcache2mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hit", hit_count, 8'd0);
        chk("rst_miss", miss_count, 8'd0);
        chk("rst_memaddr", {sif.dcache2mem_addr, sif.dcache2mem_sel}, 12'h000);
        chk("rst_memwdata", sif.dcache2mem_wdata, 16'h0000);
        chk("rst_valid", dut.valid_q, 16'h0000);

        // Cold miss with immediate mem ack
        do_store(8'h35, 16'hBEEF, 4'hF, 0, 1'b0, 16'h0);
        chk("miss_lat", lat, 4);
        chk("miss_cnt", miss_count, 8'd1);
        chk("miss_hit", hit_count, 8'd0);
        chk("miss_memaddr", m_addr, 8'h35);
        chk("miss_memwdata", m_wdata, 16'hBEEF);
        chk("miss_memsel", m_sel, 4'hF);
        chk("miss_memcyc", mem_cyc, 1);
        chk("miss_noalloc", dut.valid_q, 16'h0000);
        chk("miss_busy", busy_ok, 1'b1);

        // Fill then partial-lane hit
        do_fill(8'h35, 16'h1234);
        chk("fill_data", dut.data_q[5], 16'h1234);
        chk("fill_valid", dut.valid_q, 16'h0020);
        do_store(8'h35, 16'hABCD, 4'b0101, 0, 1'b0, 16'h0);
        chk("hit_cnt", hit_count, 8'd1);
        chk("hit_merge", dut.data_q[5], 16'h1B3D);
        chk("hit_memsel", m_sel, 4'b0101);
        chk("hit_memwdata", m_wdata, 16'hABCD);
        chk("hit_lat", lat, 4);

        // Tag mismatch on the same index
        do_fill(8'h35, 16'h1234);
        do_store(8'h45, 16'h9999, 4'hF, 0, 1'b0, 16'h0);
        chk("tagmiss_cnt", miss_count, 8'd2);
        chk("tagmiss_hitcnt", hit_count, 8'd1);
        chk("tagmiss_line", dut.data_q[5], 16'h1234);
        chk("tagmiss_memaddr", m_addr, 8'h45);

        // 10-cycle memory stall
        do_store(8'h35, 16'h1111, 4'hF, 10, 1'b0, 16'h0);
        chk("stall_memcyc", mem_cyc, 11);
        chk("stall_stable", stable, 1'b1);
        chk("stall_busy", busy_ok, 1'b1);
        chk("stall_ack_after_memack", lat - memack_cyc, 1);
        chk("stall_lat", lat, 14);
        chk("stall_hit", hit_count, 8'd2);
        chk("stall_line", dut.data_q[5], 16'h1111);

        // Empty lane mask
        do_store(8'h35, 16'h2222, 4'b0000, 0, 1'b0, 16'h0);
        chk("sel0_lat", lat, 3);
        chk("sel0_memcyc", mem_cyc, 0);
        chk("sel0_hit", hit_count, 8'd2);
        chk("sel0_miss", miss_count, 8'd2);
        chk("sel0_line", dut.data_q[5], 16'h1111);

        // Reset during MEM_WR
        @(negedge clk);
        sif.stb2dcache_req = 1'b1; sif.stb2dcache_addr = 8'h35;
        sif.stb2dcache_wdata = 16'h7777; sif.stb2dcache_sel_byte = 4'hF;
        saw_req = 1'b0;
        for (int k = 0; k < 10 && !saw_req; k++) begin
            @(negedge clk);
            if (sif.dcache2mem_req === 1'b1) saw_req = 1'b1;
        end
        chk("rstmid_reached_memwr", saw_req, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        sif.stb2dcache_req = 1'b0;
        chk("rstmid_memreq", sif.dcache2mem_req, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_counters", {hit_count, miss_count}, 16'h0000);
        chk("rstmid_valid", dut.valid_q, 16'h0000);
        any_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (sif.dcache2stb_ack === 1'b1) any_ack = 1'b1;
            @(negedge clk);
        end
        chk("rstmid_no_ack", any_ack, 1'b0);
        do_store(8'h22, 16'hCAFE, 4'hF, 0, 1'b0, 16'h0);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_miss", miss_count, 8'd1);
        chk("post_rst_memwdata", m_wdata, 16'hCAFE);

        // Fill to the same line during a hitting lookup
        do_fill(8'h35, 16'h1234);
        do_store(8'h35, 16'hFFFF, 4'hF, 0, 1'b1, 16'h5A5A);
        chk("clash_line", dut.data_q[5], 16'h5A5A);
        chk("clash_miss", miss_count, 8'd2);
        chk("clash_hit", hit_count, 8'd0);
        chk("clash_memcyc", mem_cyc, 1);
        chk("clash_memwdata", m_wdata, 16'hFFFF);

        // Hit counter saturation
        for (int i = 0; i < 300; i++) begin
            do_store(8'h35, 16'(i), 4'hF, 0, 1'b0, 16'h0);
            if (i == 253) chk("sat_254", hit_count, 8'd254);
            if (i == 254) chk("sat_255", hit_count, 8'd255);
        end
        chk("sat_hold", hit_count, 8'd255);
        chk("sat_miss", miss_count, 8'd2);
        chk("sat_line", dut.data_q[5], 16'h012B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
